execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/proc_pkg.sv | 14 +
 rtl/alu.sv | 46 ++++
 rtl/defines.sv | 20 ++
 rtl/execute_stage.sv | 127 ++++++++++++
 tb/tb_execute_stage.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared processor package.
//   exe_state_t : execute-stage state, visible to hazard/stall logic.
//     IDLE - no operation in flight
//     CALC - iterative divide in progress
//     HOLD - result presented downstream
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } exe_state_t;

endpackage

// File: rtl/alu.sv
// Combinational single-cycle ALU.
// Ports:
//   op_code (in)  operation code
//   data_a  (in)  second operand
//   data_b  (in)  first operand
//   result  (out) data_b <op> data_a, modulo 2^DATA_BITS
// Unknown codes (including DIV, which is handled elsewhere) pass data_b.
`ifndef DEFINES_SV
`include "defines.sv"
`endif

module alu #(
  parameter int DATA_BITS = `DATA_BITS
) (
  input  logic [DATA_BITS-1:0] op_code,
  input  logic [DATA_BITS-1:0] data_a,
  input  logic [DATA_BITS-1:0] data_b,
  output logic [DATA_BITS-1:0] result
);

  localparam logic [DATA_BITS-1:0] OP_ADD  = DATA_BITS'(`OP_ADD);
  localparam logic [DATA_BITS-1:0] OP_SUB  = DATA_BITS'(`OP_SUB);
  localparam logic [DATA_BITS-1:0] OP_MULT = DATA_BITS'(`OP_MULT);
  localparam logic [DATA_BITS-1:0] OP_INC  = DATA_BITS'(`OP_INC);
  localparam logic [DATA_BITS-1:0] OP_DEC  = DATA_BITS'(`OP_DEC);
  localparam logic [DATA_BITS-1:0] OP_AND  = DATA_BITS'(`OP_AND);
  localparam logic [DATA_BITS-1:0] OP_OR   = DATA_BITS'(`OP_OR);
  localparam logic [DATA_BITS-1:0] OP_XOR  = DATA_BITS'(`OP_XOR);

  // Results are sized to DATA_BITS, so sums and products wrap/truncate.
  always_comb begin
    result = data_b;
    case (op_code)
      OP_ADD:  result = data_b + data_a;
      OP_SUB:  result = data_b - data_a;
      OP_MULT: result = data_b * data_a;
      OP_INC:  result = data_b + 1'b1;
      OP_DEC:  result = data_b - 1'b1;
      OP_AND:  result = data_b & data_a;
      OP_OR:   result = data_b | data_a;
      OP_XOR:  result = data_b ^ data_a;
      default: ;
    endcase
  end

endmodule

// File: rtl/defines.sv
// Shared processor-wide definitions.
//   DATA_BITS : operand/result/opcode width used by the datapath.
//   OP_*      : operation codes carried on op_code from decode.
// Opcode values are plain numbers; users cast them to their own width.
`ifndef DEFINES_SV
`define DEFINES_SV

`define DATA_BITS 8

`define OP_ADD  0
`define OP_SUB  1
`define OP_MULT 2
`define OP_DIV  3
`define OP_INC  4
`define OP_DEC  5
`define OP_AND  6
`define OP_OR   7
`define OP_XOR  8

`endif

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative restoring divider,
// with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operation offer from decode / acceptance
//   op_code, data_A, data_B  operation; DIV computes data_B / data_A
//   out_valid / out_ready    result offer to writeback / acceptance
//   result, div_by_zero      registered result and its DIV-by-zero flag
//   busy                     high whenever an operation is in flight
`ifndef DEFINES_SV
`include "defines.sv"
`endif

module execute_stage
  import proc_pkg::*;
#(
  parameter int DATA_BITS = `DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] op_code,
  input  logic [DATA_BITS-1:0] data_A,
  input  logic [DATA_BITS-1:0] data_B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] result,
  output logic                 div_by_zero,
  output logic                 busy
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]     LAST_STEP = CNT_W'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] OP_DIV    = DATA_BITS'(`OP_DIV);

  exe_state_t state, state_next;

  logic                 accept;
  logic                 is_div;
  logic                 start_div;
  logic [DATA_BITS-1:0] alu_result;

  // Divider state: quo starts as the dividend and shifts quotient bits in
  // from the bottom as dividend bits leave from the top.
  logic [DATA_BITS-1:0] divisor;
  logic [DATA_BITS-1:0] quo;
  logic [DATA_BITS-1:0] rem;
  logic [CNT_W-1:0]     count;
  logic [DATA_BITS:0]   shifted;
  logic                 fits;
  logic [DATA_BITS-1:0] rem_next;
  logic [DATA_BITS-1:0] quo_next;

  alu #(.DATA_BITS(DATA_BITS)) u_alu (
    .op_code (op_code),
    .data_a  (data_A),
    .data_b  (data_B),
    .result  (alu_result)
  );

  // Accepting in HOLD requires out_ready, so the held result always
  // leaves on the same edge a new operation arrives.
  assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_div    = (op_code == OP_DIV);
  assign start_div = accept && is_div && (data_A != '0);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  // One restoring step: the partial remainder can reach DATA_BITS+1 bits
  // after the shift; when the top bit is set it certainly exceeds divisor,
  // and the low-bit subtraction is then exact.
  assign shifted  = {rem, quo[DATA_BITS-1]};
  assign fits     = shifted[DATA_BITS] || (shifted[DATA_BITS-1:0] >= divisor);
  assign rem_next = fits ? (shifted[DATA_BITS-1:0] - divisor) : shifted[DATA_BITS-1:0];
  assign quo_next = {quo[DATA_BITS-2:0], fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = start_div ? CALC : HOLD;
    end else begin
      case (state)
        CALC:    if (count == LAST_STEP) state_next = HOLD;
        HOLD:    if (out_ready) state_next = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor     <= '0;
      quo         <= '0;
      rem         <= '0;
      count       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (start_div) begin
        divisor <= data_A;
        quo     <= data_B;
        rem     <= '0;
        count   <= '0;
      end else begin
        // Divide by zero reports all-ones, flagged by div_by_zero.
        result      <= is_div ? '1 : alu_result;
        div_by_zero <= is_div;
      end
    end else if (state == CALC) begin
      quo   <= quo_next;
      rem   <= rem_next;
      count <= count + 1'b1;
      if (count == LAST_STEP) begin
        result      <= quo_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
`ifndef DEFINES_SV
`include "defines.sv"
`endif

module tb_execute_stage;

  localparam int W = `DATA_BITS;
  localparam logic [W-1:0] OP_ADD  = W'(`OP_ADD);
  localparam logic [W-1:0] OP_SUB  = W'(`OP_SUB);
  localparam logic [W-1:0] OP_MULT = W'(`OP_MULT);
  localparam logic [W-1:0] OP_DIV  = W'(`OP_DIV);
  localparam logic [W-1:0] OP_INC  = W'(`OP_INC);
  localparam logic [W-1:0] OP_DEC  = W'(`OP_DEC);
  localparam logic [W-1:0] OP_AND  = W'(`OP_AND);
  localparam logic [W-1:0] OP_OR   = W'(`OP_OR);
  localparam logic [W-1:0] OP_XOR  = W'(`OP_XOR);

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_code;
  logic [W-1:0] data_A;
  logic [W-1:0] data_B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         div_by_zero;
  logic         busy;

  int checks = 0;
  int errors = 0;

  execute_stage #(.DATA_BITS(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_code     (op_code),
    .data_A      (data_A),
    .data_B      (data_B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: what the operation means arithmetically.
  function automatic void model(input logic [W-1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic dz);
    dz = 1'b0;
    case (op)
      OP_ADD:  r = W'(int'(b) + int'(a));
      OP_SUB:  r = W'(int'(b) - int'(a));
      OP_MULT: r = W'(int'(b) * int'(a));
      OP_INC:  r = W'(int'(b) + 1);
      OP_DEC:  r = W'(int'(b) - 1);
      OP_AND:  r = b & a;
      OP_OR:   r = b | a;
      OP_XOR:  r = b ^ a;
      OP_DIV: begin
        if (a == '0) begin
          r  = '1;
          dz = 1'b1;
        end else begin
          r = W'(int'(b) / int'(a));
        end
      end
      default: r = b;
    endcase
  endfunction

  // Offer one op with out_ready high; measure latency from the accept edge
  // (1 = out_valid visible right after that edge) and in_ready-low cycles.
  task automatic run_op(input string name, input logic [W-1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic ed,
                        input int elat);
    int lat;
    int lowcnt;
    @(negedge clk);
    op_code = op; data_A = a; data_B = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({name, " in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    lowcnt = 0;
    while (!out_valid && lat < 4 * W) begin
      if (!in_ready) lowcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(elat));
    chk({name, " result"}, 64'(result), 64'(er));
    chk({name, " div_by_zero"}, 64'(div_by_zero), 64'(ed));
    if (elat > 1) chk({name, " ready_low_cycles"}, 64'(lowcnt), 64'(elat - 1));
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, rop, er;
    logic         ed;
    logic [W-1:0] xa[4];
    logic [W-1:0] xb[4];
    int           seen;

    vecs.push_back('{"add_wrap",  OP_ADD,  W'(100), W'(200), W'(44),  1'b0, 1});
    vecs.push_back('{"div_100_7", OP_DIV,  W'(7),   W'(100), W'(14),  1'b0, W + 1});
    vecs.push_back('{"div_zero",  OP_DIV,  W'(0),   W'(55),  W'(255), 1'b1, 1});
    vecs.push_back('{"sub",       OP_SUB,  W'(3),   W'(10),  W'(7),   1'b0, 1});
    vecs.push_back('{"sub_wrap",  OP_SUB,  W'(10),  W'(3),   W'(249), 1'b0, 1});
    vecs.push_back('{"mult_trunc",OP_MULT, W'(16),  W'(16),  W'(0),   1'b0, 1});
    vecs.push_back('{"inc_wrap",  OP_INC,  W'(9),   W'(255), W'(0),   1'b0, 1});
    vecs.push_back('{"dec_wrap",  OP_DEC,  W'(9),   W'(0),   W'(255), 1'b0, 1});
    vecs.push_back('{"and",       OP_AND,  W'(8'h3C), W'(8'hF0), W'(8'h30), 1'b0, 1});
    vecs.push_back('{"or",        OP_OR,   W'(8'h0F), W'(8'hF0), W'(8'hFF), 1'b0, 1});
    vecs.push_back('{"xor",       OP_XOR,  W'(8'hFF), W'(8'hAA), W'(8'h55), 1'b0, 1});
    vecs.push_back('{"passthru",  W'(8'h77), W'(5), W'(8'h12), W'(8'h12), 1'b0, 1});
    vecs.push_back('{"div_by_1",  OP_DIV,  W'(1),   W'(255), W'(255), 1'b0, W + 1});
    vecs.push_back('{"div_small", OP_DIV,  W'(100), W'(7),   W'(0),   1'b0, W + 1});
    vecs.push_back('{"div_equal", OP_DIV,  W'(200), W'(200), W'(1),   1'b0, W + 1});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_code = '0; data_A = '0; data_B = '0;
    #12;
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset result", 64'(result), 64'(0));
    chk("reset div_by_zero", 64'(div_by_zero), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", 64'(in_ready), 64'(1));

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz, vecs[i].lat);

    // Backpressure on a held result, then simultaneous out/in transfer.
    drain();
    @(negedge clk);
    op_code = OP_MULT; data_A = W'(20); data_B = W'(20); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", 64'(out_valid), 64'(1));
      chk("bp result", 64'(result), 64'(144));
      chk("bp in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    op_code = OP_INC; data_A = '0; data_B = W'(255); in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp swap in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp swap out_valid", 64'(out_valid), 64'(1));
    chk("bp swap result", 64'(result), 64'(0));

    // Reset in the middle of a divide.
    drain();
    @(negedge clk);
    op_code = OP_DIV; data_A = W'(7); data_B = W'(100); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("abort busy before reset", 64'(busy), 64'(1));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 64'(out_valid), 64'(0));
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort result", 64'(result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort no output", 64'(seen), 64'(0));
    run_op("after_abort_add", OP_ADD, W'(1), W'(1), W'(2), 1'b0, 1);

    // Back-to-back XOR stream: one result per cycle, in order.
    drain();
    for (int i = 0; i < 4; i++) begin
      xa[i] = W'($urandom);
      xb[i] = W'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op_code = OP_XOR; data_A = xa[i]; data_B = xb[i]; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      model(OP_XOR, xa[i], xb[i], er, ed);
      chk("stream out_valid", 64'(out_valid), 64'(1));
      chk("stream result", 64'(result), 64'(er));
    end
    @(negedge clk);
    in_valid = 1'b0;

    // Randomized ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      rop = W'($urandom_range(0, 9));
      ra  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      rb  = W'($urandom);
      model(rop, ra, rb, er, ed);
      run_op("random", rop, ra, rb, er, ed, (rop == OP_DIV && ra != '0) ? W + 1 : 1);
    end

    drain();
    chk("final idle busy", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
